// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op_e     : operation encodings driven by the control unit
//   - state_e  : sequencer states (IDLE, CALC, FIX)
//   - WIDTH_DEFAULT : default operand width; lo/hi are each this wide
//   - op_is_div / op_is_signed : op decode helpers
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the control unit (master) and
// muldiv_unit (slave).
//   start   : request strobe, sampled only while busy=0
//   op      : 00 multu, 01 mult, 10 divu, 11 div
//   a, b    : multiplicand/dividend and multiplier/divisor
//   busy    : operation in progress
//   done    : one-cycle pulse, lo/hi hold the new result
//   lo, hi  : product low/high, or quotient/remainder
//   divzero : last completed divide had b=0
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             divzero;

    modport master (
        output start, op, a, b,
        input  busy, done, lo, hi, divzero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, lo, hi, divzero
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration shared by both loops.
//   acc      : in,  2*WIDTH working register
//                   multiply: {partial product, remaining multiplier bits}
//                   divide  : {partial remainder, dividend/quotient bits}
//   operand  : in,  multiplicand magnitude or divisor magnitude
//   div_mode : in,  1 selects a restoring-division step
//   acc_next : out, acc after this iteration
// Build option: MULDIV_DIV_EN adds the divide step; without it div_mode is
// ignored and only the shift-add step exists.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
`else
    logic unused_div_mode;
    assign unused_div_mode = div_mode;
`endif

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]};
        acc_next = acc;
`ifdef MULDIV_DIV_EN
        // Shift {rem, quot} left by one; the divisor is at most 2^W-1, so
        // bit W of the difference is set exactly when the trial underflows.
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, operand};
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            // The carry out of the add becomes the new top bit after the shift.
            if (acc[0]) begin
                sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
            end
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit feeding the lo/hi registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation in flight
//   bus   : muldiv_if.slave (start/op/a/b in; busy/done/lo/hi/divzero out)
// A request runs WIDTH shift-add or restoring-division iterations on the
// operand magnitudes, then a FIX cycle applies signs and writes lo/hi.
// Build option: MULDIV_DIV_EN enables the divider; without it divide ops
// finish in two edges with lo=hi=0 and divzero=0.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH-1:0]   operand_q;
    op_e                op_q;
    logic               neg_a_q, neg_b_q, dz_q;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic               done_q, divzero_q;

    op_e                op_in;
    logic               in_div, in_neg_a, in_neg_b, in_dz;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_lo, res_hi;

    // Request decode: magnitudes are only taken for signed ops.
    always_comb begin
        op_in    = op_e'(bus.op);
        in_div   = op_is_div(op_in);
        in_neg_a = op_is_signed(op_in) & bus.a[WIDTH-1];
        in_neg_b = op_is_signed(op_in) & bus.b[WIDTH-1];
        mag_a    = in_neg_a ? -bus.a : bus.a;
        mag_b    = in_neg_b ? -bus.b : bus.b;
        in_dz    = DIV_EN && in_div && (bus.b == '0);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .operand  (operand_q),
        .div_mode (op_is_div(op_q)),
        .acc_next (acc_step)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) begin
                // Divides with nothing to iterate (b=0 or divider absent)
                // skip straight to the write-back cycle.
                state_d = (in_div && (in_dz || !DIV_EN)) ? FIX : CALC;
            end
            CALC:    if (count_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign correction and special cases, consumed only in FIX.
    always_comb begin
        prod_fix = acc_q;
        if (op_q == OP_MULT && (neg_a_q ^ neg_b_q)) prod_fix = -acc_q;
        res_lo = prod_fix[WIDTH-1:0];
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        if (op_is_div(op_q)) begin
`ifdef MULDIV_DIV_EN
            if (dz_q) begin
                // acc_q was loaded with the raw dividend for this case.
                res_lo = '1;
                res_hi = acc_q[WIDTH-1:0];
            end else begin
                res_lo = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                res_hi = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
`else
            res_lo = '0;
            res_hi = '0;
`endif
        end
    end

    // NOTE: the datapath registers are reset along with the control state so
    // an aborted operation can never leak a partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            op_q      <= OP_MULTU;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            dz_q      <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    op_q    <= op_in;
                    neg_a_q <= in_neg_a;
                    neg_b_q <= in_neg_b;
                    dz_q    <= in_dz;
                    count_q <= '0;
                    if (in_div) begin
                        acc_q     <= {{WIDTH{1'b0}}, in_dz ? bus.a : mag_a};
                        operand_q <= mag_b;
                    end else begin
                        acc_q     <= {{WIDTH{1'b0}}, mag_b};
                        operand_q <= mag_a;
                    end
                end
                CALC: begin
                    acc_q   <= acc_step;
                    count_q <= count_q + CW'(1);
                end
                FIX: begin
                    lo_q      <= res_lo;
                    hi_q      <= res_hi;
                    divzero_q <= dz_q;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.lo      = lo_q;
    assign bus.hi      = hi_q;
    assign bus.divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected results come
// from 64-bit integer arithmetic on the operands, independent of the loop.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;
    logic        last_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: lo/hi/divzero and the index of the edge after which done shows.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dz, output int done_edge);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        done_edge = W + 1;
        case (op)
            2'b00:   p = {32'h0, a} * {32'h0, b};
            2'b01:   p = sa * sb;
            default: p = '0;
        endcase
        {hi, lo} = p;
        if (op[1]) begin
`ifdef MULDIV_DIV_EN
            if (b == 32'h0) begin
                lo = 32'hFFFF_FFFF;
                hi = a;
                dz = 1'b1;
                done_edge = 1;
            end else if (op == 2'b10) begin
                lo = a / b;
                hi = a % b;
            end else begin
                longint q, r;
                q = sa / sb;
                r = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end
`else
            lo = '0;
            hi = '0;
            done_edge = 1;
`endif
        end
    endfunction

    // Issues one request at the current negedge and returns at the negedge of
    // the done cycle, so consecutive calls run back to back. poke_at>0 pulses
    // start again that many edges in, while the unit is busy.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at);
        logic [31:0] e_lo, e_hi;
        logic        e_dz;
        int          e_edge, edges, busy_cycles;
        bit          held;
        model(op, a, b, e_lo, e_hi, e_dz, e_edge);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        edges = 1;
        busy_cycles = 0;
        held = 1'b1;
        while (!bus.done && edges < 200) begin
            if (bus.busy) busy_cycles++;
            if (bus.lo !== last_lo || bus.hi !== last_hi || bus.divzero !== last_dz) held = 1'b0;
            bus.start = (edges == poke_at);
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;
        check({tag, ".done"}, bus.done, 1'b1);
        check({tag, ".done_edge"}, edges - 1, e_edge);
        check({tag, ".busy_cycles"}, busy_cycles, e_edge);
        check({tag, ".busy_clr"}, bus.busy, 1'b0);
        check({tag, ".held"}, held, 1'b1);
        check({tag, ".lo"}, bus.lo, e_lo);
        check({tag, ".hi"}, bus.hi, e_hi);
        check({tag, ".divzero"}, bus.divzero, e_dz);
        last_lo = e_lo;
        last_hi = e_hi;
        last_dz = e_dz;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.lo", bus.lo, 32'h0);
        check("rst.hi", bus.hi, 32'h0);
        check("rst.divzero", bus.divzero, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max.lo_k", bus.lo, 32'h0000_0001);
        check("multu_max.hi_k", bus.hi, 32'hFFFF_FFFE);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
        check("mult_neg.lo_k", bus.lo, 32'hFFFF_FFEB);
        check("mult_neg.hi_k", bus.hi, 32'hFFFF_FFFF);
        run_op("div_neg", OP_DIV, -32'd7, 32'd2, 0);
        run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 0);
        run_op("divu_zero", OP_DIVU, 32'h1234, 32'h0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        @(negedge clk);
        check("poke.busy", bus.busy, 1'b0);
        check("poke.done", bus.done, 1'b0);
        check("poke.lo", bus.lo, last_lo);
        check("poke.hi", bus.hi, last_hi);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), pick_val(), pick_val(), 0);
        end

        // Abort a signed multiply ten edges in; outputs clear at once.
        run_op("pre", OP_MULTU, 32'd5, 32'd9, 0);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = -32'd5;
        bus.b     = 32'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort.busy", bus.busy, 1'b0);
        check("abort.done", bus.done, 1'b0);
        check("abort.lo", bus.lo, 32'h0);
        check("abort.hi", bus.hi, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort.idle", bus.busy, 1'b0);
        check("abort.no_write", {bus.hi, bus.lo}, 64'h0);
        last_lo = '0;
        last_hi = '0;
        last_dz = 1'b0;
        run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 0);
        check("multu_6x7.lo_k", bus.lo, 32'd42);
        check("multu_6x7.hi_k", bus.hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
